// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline control path: sequencer state and the
// ID/EXE control word loaded when a bubble is inserted.
package arm_pipe_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic s;
  } id_exe_ctrl_t;

  // A bubble must not write back, touch memory or update flags.
  localparam id_exe_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch and
// memory handshake into freeze/flush/bubble controls, with wait timeout and counters.
module pipeline_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_e     state_q;
  logic [TO_W-1:0] wait_cnt_q;
  logic            mem_timeout_q;
  logic            mem_stall;

  // Priority decode: memory stall, then taken branch, then RAW hazard.
  always_comb begin
    mem_stall     = mem_req & ~mem_ready;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    freeze_all    = 1'b0;
    if (mem_stall) begin
      freeze_all   = 1'b1;
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
    end else if (branch_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
    end else if (hazard_detected) begin
      freeze_pc     = 1'b1;
      freeze_if_id  = 1'b1;
      bubble_id_exe = 1'b1;
    end
  end

  // Wait tracking; timeout is sticky and does not abort the stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (mem_stall) begin
        state_q    <= ST_MEM_WAIT;
        wait_cnt_q <= TO_W'(1);
      end
    end else begin
      if (mem_ready) begin
        state_q    <= ST_RUN;
        wait_cnt_q <= '0;
      end else begin
        if (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
          mem_timeout_q <= 1'b1;
        end
        if (wait_cnt_q != TO_W'(MEM_TIMEOUT)) begin
          wait_cnt_q <= wait_cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (freeze_pc),
    .clr_i (cnt_clr),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_if_id),
    .clr_i (cnt_clr),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller with a small timeout and 3-bit counters so
// timeout and saturation are reachable; directed scenarios plus a random run.
module tb_pipeline_stall_controller;

  localparam int unsigned MEM_TO = 4;
  localparam int unsigned CW     = 3;
  localparam int          CMAX   = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_req = 1'b0;
  logic mem_ready = 1'b0, cnt_clr = 1'b0;
  logic freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_wait;
  int m_low;
  bit m_to;
  int m_stall, m_flush;

  pipeline_stall_controller #(.MEM_TIMEOUT(MEM_TO), .TO_W(3), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .cnt_clr         (cnt_clr),
    .freeze_pc       (freeze_pc),
    .freeze_if_id    (freeze_if_id),
    .bubble_id_exe   (bubble_id_exe),
    .flush_if_id     (flush_if_id),
    .freeze_all      (freeze_all),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected {freeze_all, freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id}
  function automatic logic [4:0] exp_ctrl(logic h, logic b, logic rq, logic rd);
    if (rq && !rd) return 5'b11100;
    if (b)         return 5'b00011;
    if (h)         return 5'b01110;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] dut_ctrl();
    return {freeze_all, freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id};
  endfunction

  task automatic set_in(logic r, logic h, logic b, logic rq, logic rd, logic c);
    rst = r; hazard_detected = h; branch_taken = b;
    mem_req = rq; mem_ready = rd; cnt_clr = c;
    #1;
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    logic [4:0] c;
    c = exp_ctrl(hazard_detected, branch_taken, mem_req, mem_ready);
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_low = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (cnt_clr) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (c[3] && m_stall < CMAX) m_stall++;
        if (c[0] && m_flush < CMAX) m_flush++;
      end
      if (!m_wait) begin
        if (mem_req && !mem_ready) begin m_wait = 1; m_low = 1; end
      end else if (mem_ready) begin
        m_wait = 0; m_low = 0;
      end else begin
        m_low++;
        if (m_low >= MEM_TO) m_to = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 1, 1, 1);
    repeat (3) tick();
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dut_ctrl() !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 00000", dut_ctrl()); end
    n_checks++;
    if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    n_checks++;
    if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
    // Idle RUN state: a ready memory access causes no stall.
    set_in(0, 0, 0, 1, 1, 0);
    n_checks++;
    if (freeze_all !== 1'b0) begin n_fail++; $display("FAIL reset_run got %b want 0", freeze_all); end
    tick();
  endtask

  task automatic test_hazard();
    set_in(0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 0, 0, 0, 0);
      n_checks++;
      if (dut_ctrl() !== 5'b01110) begin n_fail++; $display("FAIL hazard_ctrl cyc %0d got %b want 01110", i, dut_ctrl()); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (stall_cnt !== 3'd2) begin n_fail++; $display("FAIL hazard_stall_cnt got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch_over_hazard();
    set_in(0, 0, 0, 0, 0, 1); tick();
    set_in(0, 1, 1, 0, 0, 0);
    n_checks++;
    if (dut_ctrl() !== 5'b00011) begin n_fail++; $display("FAIL branch_hazard_ctrl got %b want 00011", dut_ctrl()); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (flush_cnt !== 3'd1 || stall_cnt !== 3'd0) begin
      n_fail++; $display("FAIL branch_cnts got %0d/%0d want flush 1 stall 0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    set_in(0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, 1, 0, 0);
      n_checks++;
      if (dut_ctrl() !== 5'b11100) begin n_fail++; $display("FAIL mem_wait_ctrl cyc %0d got %b want 11100", i, dut_ctrl()); end
      tick();
    end
    set_in(0, 0, 1, 1, 1, 0);
    n_checks++;
    if (dut_ctrl() !== 5'b00011) begin n_fail++; $display("FAIL mem_release_ctrl got %b want 00011", dut_ctrl()); end
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (stall_cnt !== 3'd5 || flush_cnt !== 3'd1) begin
      n_fail++; $display("FAIL mem_wait_cnts got %0d/%0d want stall 5 flush 1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    set_in(1, 0, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 6; i++) begin
      set_in(0, 0, 0, 1, 0, 0);
      tick();
      n_checks++;
      if (mem_timeout !== (i >= 4)) begin
        n_fail++; $display("FAIL timeout after wait %0d got %b want %b", i, mem_timeout, (i >= 4));
      end
    end
    set_in(0, 0, 0, 1, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", mem_timeout); end
  endtask

  task automatic test_saturation();
    set_in(0, 0, 0, 0, 0, 1); tick();
    for (int i = 1; i <= 9; i++) begin
      set_in(0, 1, 0, 0, 0, 0);
      tick();
    end
    n_checks++;
    if (stall_cnt !== 3'd7) begin n_fail++; $display("FAIL stall_saturate got %0d want 7", stall_cnt); end
    set_in(0, 1, 0, 0, 0, 1); tick();
    n_checks++;
    if (stall_cnt !== 3'd0) begin n_fail++; $display("FAIL clr_over_inc got %0d want 0", stall_cnt); end
    for (int i = 1; i <= 9; i++) begin
      set_in(0, 0, 1, 0, 0, 0);
      tick();
    end
    n_checks++;
    if (flush_cnt !== 3'd7) begin n_fail++; $display("FAIL flush_saturate got %0d want 7", flush_cnt); end
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4),
             ($urandom_range(0, 29) == 0));
      e = exp_ctrl(hazard_detected, branch_taken, mem_req, mem_ready);
      n_checks++;
      if (dut_ctrl() !== e) begin n_fail++; $display("FAIL rand_ctrl cyc %0d got %b want %b", i, dut_ctrl(), e); end
      tick();
      n_checks++;
      if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || mem_timeout !== m_to) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d got stall %0d flush %0d to %b want %0d %0d %b",
                 i, stall_cnt, flush_cnt, mem_timeout, m_stall, m_flush, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch_over_hazard();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
